// File: rtl/qspi_slave_core_pkg.sv
// Shared definitions for the multi-lane SPI slave: FSM encodings and width helpers.
package qspi_slave_core_pkg;

    // state   | meaning
    // IDLE    | no frame, waiting for synced ss fall
    // CMD     | shifting in the command word
    // TURN    | dummy sclk cycles before read data
    // RD      | driving tx words on falling sclk
    // WR      | shifting rx words into the holding register
    localparam logic [2:0] ST_IDLE = 3'd0;
    localparam logic [2:0] ST_CMD  = 3'd1;
    localparam logic [2:0] ST_TURN = 3'd2;
    localparam logic [2:0] ST_RD   = 3'd3;
    localparam logic [2:0] ST_WR   = 3'd4;

    function automatic int qspi_cnt_w(input int lanes, input int data_w);
        return $clog2(data_w / lanes) + 1;
    endfunction

    function automatic int qspi_turn_w(input int turn);
        return $clog2(turn + 1) + 1;
    endfunction

endpackage

// File: rtl/qspi_slave_core_if.sv
// Pin and stream bundle between the SPI slave core and its surroundings.
interface qspi_slave_core_if #(
    parameter int LANES  = 2,
    parameter int DATA_W = 8
);
    logic              io_ss;
    logic              io_sclk;
    logic [LANES-1:0]  io_qd_read;
    logic [LANES-1:0]  io_qd_write;
    logic [LANES-1:0]  io_qd_writeEnable;
    logic [DATA_W-1:0] io_cmd;
    logic              io_cmd_valid;
    logic [DATA_W-1:0] io_rx_data;
    logic              io_rx_valid;
    logic              io_rx_ready;
    logic [DATA_W-1:0] io_tx_data;
    logic              io_tx_valid;
    logic              io_tx_ready;
    logic              io_busy;
    logic              io_rx_overrun;
    logic              io_tx_underrun;

    modport slave (
        input  io_ss, io_sclk, io_qd_read, io_rx_ready, io_tx_data, io_tx_valid,
        output io_qd_write, io_qd_writeEnable, io_cmd, io_cmd_valid, io_rx_data,
               io_rx_valid, io_tx_ready, io_busy, io_rx_overrun, io_tx_underrun
    );

    modport master (
        output io_ss, io_sclk, io_qd_read, io_rx_ready, io_tx_data, io_tx_valid,
        input  io_qd_write, io_qd_writeEnable, io_cmd, io_cmd_valid, io_rx_data,
               io_rx_valid, io_tx_ready, io_busy, io_rx_overrun, io_tx_underrun
    );
endinterface

// File: rtl/qspi_slave_core_sync_edge.sv
// Two-flop synchroniser followed by an edge-detect flop, for a bundle of W bits.
module qspi_slave_core_sync_edge #(
    parameter int W = 1
) (
    input  logic         clk,
    input  logic         reset,
    input  logic [W-1:0] d_in,
    output logic [W-1:0] level,
    output logic [W-1:0] rise,
    output logic [W-1:0] fall
);
    logic [W-1:0] meta_q, meta_d;
    logic [W-1:0] sync_q, sync_d;
    logic [W-1:0] prev_q, prev_d;

    always_comb begin
        meta_d = d_in;
        sync_d = meta_q;
        prev_d = sync_q;
    end

    // Reset to 0 so a pin already low after reset produces no fall edge.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            meta_q <= '0;
            sync_q <= '0;
            prev_q <= '0;
        end else begin
            meta_q <= meta_d;
            sync_q <= sync_d;
            prev_q <= prev_d;
        end
    end

    assign level = sync_q;
    assign rise  = sync_q & ~prev_q;
    assign fall  = ~sync_q & prev_q;
endmodule

// File: rtl/qspi_slave_core.sv
// Multi-lane SPI slave engine: oversampled mode-0 pins, command word, then write or read stream.
module qspi_slave_core
    import qspi_slave_core_pkg::*;
#(
    parameter int          LANES   = 2,
    parameter int          DATA_W  = 8,
    parameter int          TURN    = 2,
    parameter logic [31:0] IDLE_TX = 32'hFF
) (
    input logic              clk,
    input logic              reset,
    qspi_slave_core_if.slave bus
);
    localparam int SHIFTS = DATA_W / LANES;
    localparam int CNT_W  = qspi_cnt_w(LANES, DATA_W);
    localparam int TURN_W = qspi_turn_w(TURN);

    localparam logic [CNT_W-1:0]  LAST_SHIFT  = CNT_W'(SHIFTS - 1);
    localparam logic [CNT_W-1:0]  WORD_SHIFTS = CNT_W'(SHIFTS);
    localparam logic [TURN_W-1:0] TURN_LAST   = TURN_W'((TURN > 0) ? TURN - 1 : 0);
    localparam logic [DATA_W-1:0] IDLE_WORD   = DATA_W'(IDLE_TX);

    logic             ss_lvl, ss_rise, ss_fall;
    logic             sclk_lvl, sclk_rise, sclk_fall;
    logic [LANES-1:0] lanes_s, lanes_rise, lanes_fall;

    qspi_slave_core_sync_edge #(.W(1)) u_sync_ss (
        .clk(clk), .reset(reset), .d_in(bus.io_ss),
        .level(ss_lvl), .rise(ss_rise), .fall(ss_fall)
    );

    qspi_slave_core_sync_edge #(.W(1)) u_sync_sclk (
        .clk(clk), .reset(reset), .d_in(bus.io_sclk),
        .level(sclk_lvl), .rise(sclk_rise), .fall(sclk_fall)
    );

    qspi_slave_core_sync_edge #(.W(LANES)) u_sync_lanes (
        .clk(clk), .reset(reset), .d_in(bus.io_qd_read),
        .level(lanes_s), .rise(lanes_rise), .fall(lanes_fall)
    );

    wire unused_sync = &{1'b0, ss_lvl, sclk_lvl, lanes_rise, lanes_fall};

    logic [2:0]        state_q, state_d;
    logic [DATA_W-1:0] shreg_q, shreg_d;
    logic [DATA_W-1:0] tx_shreg_q, tx_shreg_d;
    logic [DATA_W-1:0] cmd_q, cmd_d;
    logic [DATA_W-1:0] rx_data_q, rx_data_d;
    logic [CNT_W-1:0]  bit_cnt_q, bit_cnt_d;
    logic [CNT_W-1:0]  tx_cnt_q, tx_cnt_d;
    logic [TURN_W-1:0] turn_cnt_q, turn_cnt_d;
    logic [LANES-1:0]  qd_out_q, qd_out_d;
    logic              oe_q, oe_d;
    logic              cmd_valid_q, cmd_valid_d;
    logic              rx_valid_q, rx_valid_d;
    logic              rx_overrun_q, rx_overrun_d;
    logic              tx_underrun_q, tx_underrun_d;
    logic              tx_ready_q, tx_ready_d;
    logic              busy_q, busy_d;

    logic [DATA_W-1:0] word_next;
    logic [DATA_W-1:0] tx_word;
    logic              word_done;

    always_comb begin
        state_d       = state_q;
        shreg_d       = shreg_q;
        tx_shreg_d    = tx_shreg_q;
        cmd_d         = cmd_q;
        rx_data_d     = rx_data_q;
        bit_cnt_d     = bit_cnt_q;
        tx_cnt_d      = tx_cnt_q;
        turn_cnt_d    = turn_cnt_q;
        qd_out_d      = qd_out_q;
        cmd_valid_d   = 1'b0;
        rx_valid_d    = rx_valid_q;
        rx_overrun_d  = rx_overrun_q;
        tx_underrun_d = tx_underrun_q;
        tx_ready_d    = 1'b0;
        busy_d        = busy_q;

        word_next = DATA_W'({shreg_q, lanes_s});
        word_done = (bit_cnt_q == LAST_SHIFT);
        tx_word   = bus.io_tx_valid ? bus.io_tx_data : IDLE_WORD;

        if (rx_valid_q && bus.io_rx_ready) begin
            rx_valid_d = 1'b0;
        end

        if (ss_rise) begin
            state_d    = ST_IDLE;
            busy_d     = 1'b0;
            bit_cnt_d  = '0;
            tx_cnt_d   = '0;
            turn_cnt_d = '0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (ss_fall) begin
                        state_d       = ST_CMD;
                        busy_d        = 1'b1;
                        rx_overrun_d  = 1'b0;
                        tx_underrun_d = 1'b0;
                        bit_cnt_d     = '0;
                        qd_out_d      = '0;
                    end
                end
                ST_CMD: begin
                    if (sclk_rise) begin
                        shreg_d   = word_next;
                        bit_cnt_d = bit_cnt_q + 1'b1;
                        if (word_done) begin
                            bit_cnt_d   = '0;
                            cmd_d       = word_next;
                            cmd_valid_d = 1'b1;
                            if (word_next[DATA_W-1]) begin
                                // First read word is fetched as the turnaround begins.
                                state_d       = (TURN == 0) ? ST_RD : ST_TURN;
                                turn_cnt_d    = '0;
                                tx_shreg_d    = tx_word;
                                tx_cnt_d      = '0;
                                tx_ready_d    = bus.io_tx_valid;
                                tx_underrun_d = tx_underrun_q | ~bus.io_tx_valid;
                            end else begin
                                state_d = ST_WR;
                            end
                        end
                    end
                end
                ST_TURN: begin
                    if (sclk_rise) begin
                        if (turn_cnt_q == TURN_LAST) begin
                            state_d = ST_RD;
                        end else begin
                            turn_cnt_d = turn_cnt_q + 1'b1;
                        end
                    end
                end
                ST_RD: begin
                    if (sclk_fall) begin
                        // A new word is fetched only when its first bits are needed.
                        if (tx_cnt_q == WORD_SHIFTS) begin
                            qd_out_d      = tx_word[DATA_W-1 -: LANES];
                            tx_shreg_d    = tx_word << LANES;
                            tx_cnt_d      = CNT_W'(1);
                            tx_ready_d    = bus.io_tx_valid;
                            tx_underrun_d = tx_underrun_q | ~bus.io_tx_valid;
                        end else begin
                            qd_out_d   = tx_shreg_q[DATA_W-1 -: LANES];
                            tx_shreg_d = tx_shreg_q << LANES;
                            tx_cnt_d   = tx_cnt_q + 1'b1;
                        end
                    end
                end
                ST_WR: begin
                    if (sclk_rise) begin
                        shreg_d   = word_next;
                        bit_cnt_d = bit_cnt_q + 1'b1;
                        if (word_done) begin
                            bit_cnt_d = '0;
                            if (!rx_valid_q || bus.io_rx_ready) begin
                                rx_data_d  = word_next;
                                rx_valid_d = 1'b1;
                            end else begin
                                rx_overrun_d = 1'b1;
                            end
                        end
                    end
                end
                default: state_d = ST_IDLE;
            endcase
        end

        oe_d = (state_d == ST_RD);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q       <= ST_IDLE;
            shreg_q       <= '0;
            tx_shreg_q    <= '0;
            cmd_q         <= '0;
            rx_data_q     <= '0;
            bit_cnt_q     <= '0;
            tx_cnt_q      <= '0;
            turn_cnt_q    <= '0;
            qd_out_q      <= '0;
            oe_q          <= 1'b0;
            cmd_valid_q   <= 1'b0;
            rx_valid_q    <= 1'b0;
            rx_overrun_q  <= 1'b0;
            tx_underrun_q <= 1'b0;
            tx_ready_q    <= 1'b0;
            busy_q        <= 1'b0;
        end else begin
            state_q       <= state_d;
            shreg_q       <= shreg_d;
            tx_shreg_q    <= tx_shreg_d;
            cmd_q         <= cmd_d;
            rx_data_q     <= rx_data_d;
            bit_cnt_q     <= bit_cnt_d;
            tx_cnt_q      <= tx_cnt_d;
            turn_cnt_q    <= turn_cnt_d;
            qd_out_q      <= qd_out_d;
            oe_q          <= oe_d;
            cmd_valid_q   <= cmd_valid_d;
            rx_valid_q    <= rx_valid_d;
            rx_overrun_q  <= rx_overrun_d;
            tx_underrun_q <= tx_underrun_d;
            tx_ready_q    <= tx_ready_d;
            busy_q        <= busy_d;
        end
    end

    assign bus.io_qd_write       = qd_out_q;
    assign bus.io_qd_writeEnable = {LANES{oe_q}};
    assign bus.io_cmd            = cmd_q;
    assign bus.io_cmd_valid      = cmd_valid_q;
    assign bus.io_rx_data        = rx_data_q;
    assign bus.io_rx_valid       = rx_valid_q;
    assign bus.io_tx_ready       = tx_ready_q;
    assign bus.io_busy           = busy_q;
    assign bus.io_rx_overrun     = rx_overrun_q;
    assign bus.io_tx_underrun    = tx_underrun_q;
endmodule

// File: tb/tb_qspi_slave_core.sv
// Directed bench for qspi_slave_core: 2-lane instance for the main scenarios, 1- and 4-lane write regressions.
module tb_qspi_slave_core;
    localparam int T_HALF = 80;

    logic       clk;
    logic       reset;
    logic       sclk;
    logic [2:0] ss_n;
    logic [3:0] lanes;
    int         checks = 0;
    int         errors = 0;

    qspi_slave_core_if #(.LANES(2), .DATA_W(8)) bus2 ();
    qspi_slave_core_if #(.LANES(1), .DATA_W(8)) bus1 ();
    qspi_slave_core_if #(.LANES(4), .DATA_W(8)) bus4 ();

    qspi_slave_core #(.LANES(2), .DATA_W(8), .TURN(2), .IDLE_TX(32'hFF)) u_dut2 (
        .clk(clk), .reset(reset), .bus(bus2.slave));
    qspi_slave_core #(.LANES(1), .DATA_W(8), .TURN(2), .IDLE_TX(32'hFF)) u_dut1 (
        .clk(clk), .reset(reset), .bus(bus1.slave));
    qspi_slave_core #(.LANES(4), .DATA_W(8), .TURN(2), .IDLE_TX(32'hFF)) u_dut4 (
        .clk(clk), .reset(reset), .bus(bus4.slave));

    assign bus2.io_ss      = ss_n[0];
    assign bus1.io_ss      = ss_n[1];
    assign bus4.io_ss      = ss_n[2];
    assign bus2.io_sclk    = sclk;
    assign bus1.io_sclk    = sclk;
    assign bus4.io_sclk    = sclk;
    assign bus2.io_qd_read = lanes[1:0];
    assign bus1.io_qd_read = lanes[0:0];
    assign bus4.io_qd_read = lanes;
    assign bus1.io_rx_ready = 1'b1;
    assign bus4.io_rx_ready = 1'b1;
    assign bus1.io_tx_valid = 1'b0;
    assign bus4.io_tx_valid = 1'b0;
    assign bus1.io_tx_data  = 8'h00;
    assign bus4.io_tx_data  = 8'h00;

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    logic [7:0] rxq2[$];
    logic [7:0] rxq1[$];
    logic [7:0] rxq4[$];
    int         cmd_cnt2 = 0, cmd_cnt1 = 0, cmd_cnt4 = 0, txr_cnt2 = 0;
    logic       oe_seen2 = 1'b0;

    always @(negedge clk) begin
        if (bus2.io_rx_valid && bus2.io_rx_ready) rxq2.push_back(bus2.io_rx_data);
        if (bus1.io_rx_valid) rxq1.push_back(bus1.io_rx_data);
        if (bus4.io_rx_valid) rxq4.push_back(bus4.io_rx_data);
        if (bus2.io_cmd_valid) cmd_cnt2++;
        if (bus1.io_cmd_valid) cmd_cnt1++;
        if (bus4.io_cmd_valid) cmd_cnt4++;
        if (bus2.io_tx_ready) txr_cnt2++;
        if (bus2.io_qd_writeEnable != 2'b00) oe_seen2 = 1'b1;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic sclk_cycle(input logic [3:0] d);
        lanes = d;
        #(T_HALF);
        sclk = 1'b1;
        #(T_HALF);
        sclk = 1'b0;
    endtask

    task automatic send_word(input int n, input logic [7:0] w);
        logic [7:0] tmp;
        tmp = w;
        for (int i = 0; i < 8 / n; i++) begin
            sclk_cycle(4'(tmp >> (8 - n)));
            tmp = tmp << n;
        end
    endtask

    // Samples the 2-lane output just before the rise; caller lowers sclk.
    task automatic read_rise(output logic [1:0] q);
        lanes = 4'h0;
        #(T_HALF);
        q = bus2.io_qd_write;
        sclk = 1'b1;
        #(T_HALF);
    endtask

    task automatic frame_begin(input int idx);
        ss_n[idx] = 1'b0;
        #(T_HALF);
    endtask

    task automatic frame_end(input int idx);
        #(T_HALF);
        ss_n[idx] = 1'b1;
        #(2 * T_HALF);
    endtask

    initial begin
        logic [1:0] q;
        logic [1:0] exp_c3 [4];
        int         base;
        exp_c3 = '{2'b11, 2'b00, 2'b00, 2'b11};

        reset = 1'b1;
        sclk  = 1'b0;
        ss_n  = 3'b111;
        lanes = 4'h0;
        bus2.io_rx_ready = 1'b1;
        bus2.io_tx_valid = 1'b0;
        bus2.io_tx_data  = 8'h00;
        #20;
        check("rst_we", 32'(bus2.io_qd_writeEnable), 32'h0);
        check("rst_qd", 32'(bus2.io_qd_write), 32'h0);
        check("rst_busy", 32'(bus2.io_busy), 32'h0);
        check("rst_cmd", 32'(bus2.io_cmd), 32'h0);
        check("rst_rxv", 32'(bus2.io_rx_valid), 32'h0);
        #20;
        reset = 1'b0;
        #40;

        // Test 1: 2-lane write frame
        frame_begin(0);
        check("t1_busy", 32'(bus2.io_busy), 32'h1);
        send_word(2, 8'h12);
        send_word(2, 8'hA5);
        send_word(2, 8'h3C);
        frame_end(0);
        check("t1_cmd_cnt", 32'(cmd_cnt2), 32'd1);
        check("t1_cmd", 32'(bus2.io_cmd), 32'h12);
        check("t1_rx_cnt", 32'(rxq2.size()), 32'd2);
        if (rxq2.size() == 2) begin
            check("t1_rx0", 32'(rxq2[0]), 32'hA5);
            check("t1_rx1", 32'(rxq2[1]), 32'h3C);
        end
        check("t1_we_never", 32'(oe_seen2), 32'h0);
        check("t1_busy_end", 32'(bus2.io_busy), 32'h0);

        // Test 2: read with TURN=2, tx word C3
        bus2.io_tx_valid = 1'b1;
        bus2.io_tx_data  = 8'hC3;
        base = txr_cnt2;
        frame_begin(0);
        send_word(2, 8'h80);
        sclk_cycle(4'h0);
        sclk_cycle(4'h0);
        for (int i = 0; i < 4; i++) begin
            read_rise(q);
            check("t2_lanes", 32'(q), 32'(exp_c3[i]));
            if (i == 0) check("t2_we", 32'(bus2.io_qd_writeEnable), 32'h3);
            if (i == 3) check("t2_tx_ready_once", 32'(txr_cnt2 - base), 32'd1);
            sclk = 1'b0;
        end
        frame_end(0);
        check("t2_we_off", 32'(bus2.io_qd_writeEnable), 32'h0);
        check("t2_no_underrun", 32'(bus2.io_tx_underrun), 32'h0);

        // Test 3: read underrun shifts out FF
        bus2.io_tx_valid = 1'b0;
        frame_begin(0);
        send_word(2, 8'h80);
        sclk_cycle(4'h0);
        sclk_cycle(4'h0);
        for (int i = 0; i < 4; i++) begin
            read_rise(q);
            check("t3_lanes", 32'(q), 32'h3);
            sclk = 1'b0;
        end
        frame_end(0);
        check("t3_underrun", 32'(bus2.io_tx_underrun), 32'h1);

        // Test 4: overrun with rx_ready low
        rxq2.delete();
        bus2.io_rx_ready = 1'b0;
        frame_begin(0);
        check("t4_underrun_clr", 32'(bus2.io_tx_underrun), 32'h0);
        send_word(2, 8'h20);
        send_word(2, 8'h11);
        send_word(2, 8'h22);
        send_word(2, 8'h33);
        frame_end(0);
        check("t4_rxv", 32'(bus2.io_rx_valid), 32'h1);
        check("t4_rxd", 32'(bus2.io_rx_data), 32'h11);
        check("t4_overrun", 32'(bus2.io_rx_overrun), 32'h1);
        bus2.io_rx_ready = 1'b1;
        #20;
        check("t4_rxv_drop", 32'(bus2.io_rx_valid), 32'h0);
        check("t4_rx_cnt", 32'(rxq2.size()), 32'd1);

        // Test 5: aborted partial frame then cmd 0x01
        rxq2.delete();
        base = cmd_cnt2;
        frame_begin(0);
        check("t5_overrun_clr", 32'(bus2.io_rx_overrun), 32'h0);
        sclk_cycle(4'h3);
        sclk_cycle(4'h3);
        sclk_cycle(4'h3);
        frame_end(0);
        frame_begin(0);
        send_word(2, 8'h01);
        frame_end(0);
        check("t5_cmd_cnt", 32'(cmd_cnt2 - base), 32'd1);
        check("t5_cmd", 32'(bus2.io_cmd), 32'h01);
        check("t5_rx_none", 32'(rxq2.size()), 32'd0);
        check("t5_rxv", 32'(bus2.io_rx_valid), 32'h0);

        // Test 6a: 1-lane and 4-lane write regressions
        frame_begin(1);
        send_word(1, 8'h12);
        send_word(1, 8'hA5);
        send_word(1, 8'h3C);
        frame_end(1);
        check("l1_cmd_cnt", 32'(cmd_cnt1), 32'd1);
        check("l1_cmd", 32'(bus1.io_cmd), 32'h12);
        check("l1_rx_cnt", 32'(rxq1.size()), 32'd2);
        if (rxq1.size() == 2) begin
            check("l1_rx0", 32'(rxq1[0]), 32'hA5);
            check("l1_rx1", 32'(rxq1[1]), 32'h3C);
        end
        check("l1_we", 32'(bus1.io_qd_writeEnable), 32'h0);
        frame_begin(2);
        send_word(4, 8'h12);
        send_word(4, 8'hA5);
        send_word(4, 8'h3C);
        frame_end(2);
        check("l4_cmd_cnt", 32'(cmd_cnt4), 32'd1);
        check("l4_cmd", 32'(bus4.io_cmd), 32'h12);
        check("l4_rx_cnt", 32'(rxq4.size()), 32'd2);
        if (rxq4.size() == 2) begin
            check("l4_rx0", 32'(rxq4[0]), 32'hA5);
            check("l4_rx1", 32'(rxq4[1]), 32'h3C);
        end
        check("l4_we", 32'(bus4.io_qd_writeEnable), 32'h0);

        // Test 6b: reset asserted mid-read
        bus2.io_tx_valid = 1'b1;
        bus2.io_tx_data  = 8'hC3;
        frame_begin(0);
        send_word(2, 8'h80);
        sclk_cycle(4'h0);
        sclk_cycle(4'h0);
        read_rise(q);
        check("t6_lanes", 32'(q), 32'h3);
        check("t6_we_on", 32'(bus2.io_qd_writeEnable), 32'h3);
        sclk = 1'b0;
        #20;
        reset = 1'b1;
        #1;
        check("t6_we_rst", 32'(bus2.io_qd_writeEnable), 32'h0);
        check("t6_busy_rst", 32'(bus2.io_busy), 32'h0);
        check("t6_cmd_rst", 32'(bus2.io_cmd), 32'h0);
        #19;
        reset = 1'b0;
        #40;
        sclk_cycle(4'h0);
        sclk_cycle(4'h0);
        check("t6_ss_low_ignored", 32'(bus2.io_busy), 32'h0);
        frame_end(0);
        rxq2.delete();
        frame_begin(0);
        check("t6_busy_new", 32'(bus2.io_busy), 32'h1);
        send_word(2, 8'h12);
        send_word(2, 8'h77);
        frame_end(0);
        check("t6_cmd", 32'(bus2.io_cmd), 32'h12);
        check("t6_rx_cnt", 32'(rxq2.size()), 32'd1);
        if (rxq2.size() == 1) check("t6_rx0", 32'(rxq2[0]), 32'h77);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
